// File: rtl/seg7_pkg.sv
// Shared constants and the hex-to-segment decoder used by the scrolling display.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

  localparam logic [6:0] SEG7_BLANK = 7'h7F;

  function automatic logic [6:0] seg7_decode(input logic [3:0] val);
    logic [6:0] segs;
    case (val)
      4'h0:    segs = 7'h40;
      4'h1:    segs = 7'h79;
      4'h2:    segs = 7'h24;
      4'h3:    segs = 7'h30;
      4'h4:    segs = 7'h19;
      4'h5:    segs = 7'h12;
      4'h6:    segs = 7'h02;
      4'h7:    segs = 7'h78;
      4'h8:    segs = 7'h00;
      4'h9:    segs = 7'h10;
      4'hA:    segs = 7'h08;
      4'hB:    segs = 7'h03;
      4'hC:    segs = 7'h46;
      4'hD:    segs = 7'h21;
      4'hE:    segs = 7'h06;
      default: segs = 7'h0E;
    endcase
    return segs;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running modulo-DIV counter; tick is high for the single cycle in which
// the count sits at DIV-1.
module tick_divider #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/seg7_scroll_display.sv
// N-digit multiplexed seven-segment driver with a rotatable view window.
// Physical slot p shows regs[(p + offset) mod NUM_DIGITS]; seg/an are registered.
module seg7_scroll_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SEL_W      = 4,
  parameter int SCAN_DIV   = 100_000,
  parameter int SCROLL_DIV = 100_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write,
  input  logic [SEL_W-1:0]      sel,
  input  logic [3:0]            num,
  input  logic                  scroll_en,
  input  logic                  direction,
  input  logic [NUM_DIGITS-1:0] blank_mask,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  scan_tick,
  output logic                  scroll_tick
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [IW:0]   NUM_W    = (IW + 1)'(NUM_DIGITS);

  logic [NUM_DIGITS-1:0][3:0] regs_q, regs_d;
  logic [IW-1:0]              scan_idx_q, scan_idx_d;
  logic [IW-1:0]              offset_q, offset_d;
  logic [6:0]                 seg_q, seg_d;
  logic [NUM_DIGITS-1:0]      an_q, an_d;
  logic [NUM_DIGITS-1:0]      wr_en;
  logic [NUM_DIGITS-1:0]      pos_hot;
  logic [IW:0]                src_sum;
  logic [IW-1:0]              src_idx;

  tick_divider #(.DIV(SCAN_DIV)) u_scan_div (
    .clk  (clk),
    .reset(reset),
    .tick (scan_tick)
  );

  tick_divider #(.DIV(SCROLL_DIV)) u_scroll_div (
    .clk  (clk),
    .reset(reset),
    .tick (scroll_tick)
  );

  // Full-width compare so out-of-range sel values match no digit.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign wr_en[gi]   = write && ({1'b0, sel} == (SEL_W + 1)'(gi));
    assign pos_hot[gi] = (scan_idx_q == IW'(gi));
  end

  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (wr_en[i]) regs_d[i] = num;
    end
  end

  always_comb begin
    scan_idx_d = scan_idx_q;
    if (scan_tick) scan_idx_d = (scan_idx_q == LAST_IDX) ? '0 : scan_idx_q + 1'b1;
  end

  always_comb begin
    offset_d = offset_q;
    if (scroll_tick && scroll_en) begin
      if (direction) offset_d = (offset_q == LAST_IDX) ? '0 : offset_q + 1'b1;
      else           offset_d = (offset_q == '0) ? LAST_IDX : offset_q - 1'b1;
    end
  end

  always_comb begin
    src_sum = {1'b0, scan_idx_q} + {1'b0, offset_q};
    src_idx = (src_sum >= NUM_W) ? IW'(src_sum - NUM_W) : IW'(src_sum);
    if (blank_mask[scan_idx_q]) begin
      seg_d = SEG7_BLANK;
      an_d  = '1;
    end else begin
      seg_d = seg7_decode(regs_q[src_idx]);
      an_d  = ~pos_hot;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q     <= '0;
      scan_idx_q <= '0;
      offset_q   <= '0;
      seg_q      <= SEG7_BLANK;
      an_q       <= '1;
    end else begin
      regs_q     <= regs_d;
      scan_idx_q <= scan_idx_d;
      offset_q   <= offset_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg7_scroll_display.sv
// Scoreboard bench: stimulus queues expected slot contents keyed by epoch/cycle,
// a negedge monitor pops and compares them whenever the DUT raises scan_tick.
module tb_seg7_scroll_display;

  localparam int ND = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       write = 1'b0;
  logic [3:0] sel = 4'h0;
  logic [3:0] num = 4'h0;
  logic       scroll_en = 1'b0;
  logic       direction = 1'b1;
  logic [7:0] blank_mask = 8'h00;
  logic [6:0] seg;
  logic [7:0] an;
  logic       scan_tick;
  logic       scroll_tick;

  always #5 clk = ~clk;

  seg7_scroll_display #(
    .NUM_DIGITS(ND),
    .SEL_W     (4),
    .SCAN_DIV  (4),
    .SCROLL_DIV(64)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .write      (write),
    .sel        (sel),
    .num        (num),
    .scroll_en  (scroll_en),
    .direction  (direction),
    .blank_mask (blank_mask),
    .seg        (seg),
    .an         (an),
    .scan_tick  (scan_tick),
    .scroll_tick(scroll_tick)
  );

  typedef struct {
    int         key;
    logic [7:0] an;
    logic [6:0] seg;
    logic       sct;
  } slot_t;

  typedef struct {
    int          key;
    logic [16:0] obs;
  } direct_t;

  slot_t   sb_q[$];
  direct_t dq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int epoch = 0;
  bit watch_fe = 1'b0;
  bit done = 1'b0;

  logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [3:0] regs_exp [ND];

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic push_direct(input int key, input logic [16:0] obs);
    direct_t d;
    d.key = key;
    d.obs = obs;
    dq.push_back(d);
  endtask

  // Slot k of the current epoch is presented in cycle 4k+3 (scan_tick high).
  task automatic push_slots(input int k0, input int n, input int off, input logic [7:0] bm);
    for (int k = k0; k < k0 + n; k++) begin
      slot_t e;
      int p;
      int src;
      p   = k % ND;
      src = (p + off) % ND;
      e.key = epoch * 100000 + 4 * k + 3;
      e.an  = bm[p] ? 8'hFF : ~(8'h01 << p);
      e.seg = bm[p] ? 7'h7F : segtab[regs_exp[src]];
      e.sct = ((k % 16) == 15);
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    int          cur;
    direct_t     d;
    slot_t       s;
    logic [16:0] obs;
    if (done) begin
      while (dq.size() > 0) begin
        d = dq.pop_front();
        checks++;
        errors++;
        $display("FAIL direct_unchecked key=%0d want %h", d.key, d.obs);
      end
      while (sb_q.size() > 0) begin
        s = sb_q.pop_front();
        checks++;
        errors++;
        $display("FAIL slot_unchecked key=%0d want an=%h seg=%h", s.key, s.an, s.seg);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end else begin
      cur = epoch * 100000 + cyc;
      obs = {an, seg, scan_tick, scroll_tick};
      if (dq.size() > 0 && dq[0].key <= cur) begin
        d = dq.pop_front();
        checks++;
        if (d.key != cur || obs !== d.obs) begin
          errors++;
          $display("FAIL direct key=%0d at=%0d got {an,seg,st,rt}=%h want %h", d.key, cur, obs, d.obs);
        end
      end
      if (!reset && scan_tick) begin
        checks++;
        if ((cyc % 4) != 3) begin
          errors++;
          $display("FAIL scan_phase cyc=%0d got phase %0d want 3", cyc, cyc % 4);
        end
        while (sb_q.size() > 0 && sb_q[0].key < cur) begin
          s = sb_q.pop_front();
          checks++;
          errors++;
          $display("FAIL slot_missed key=%0d seen at %0d", s.key, cur);
        end
        if (sb_q.size() > 0 && sb_q[0].key == cur) begin
          s = sb_q.pop_front();
          checks++;
          if (an !== s.an || seg !== s.seg || scroll_tick !== s.sct) begin
            errors++;
            $display("FAIL slot key=%0d got an=%h seg=%h rt=%b want an=%h seg=%h rt=%b",
                     s.key, an, seg, scroll_tick, s.an, s.seg, s.sct);
          end else begin
            $display("slot key=%0d an=%h seg=%h ok", s.key, an, seg);
          end
        end
      end
      if (!reset && scroll_tick) begin
        checks++;
        if ((cyc % 64) != 63) begin
          errors++;
          $display("FAIL scroll_phase cyc=%0d got phase %0d want 63", cyc, cyc % 64);
        end
      end
      if (watch_fe) begin
        checks++;
        if (an === 8'hFE) begin
          errors++;
          $display("FAIL blank_pos0 cyc=%0d got an=%h want not FE", cyc, an);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) push_direct(0, {8'hFF, 7'h7F, 1'b0, 1'b0});
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < ND; i++) regs_exp[i] = 4'(i + 1);
    push_direct(4, {8'hFE, 7'h79, 1'b0, 1'b0});
    push_slots(0,   16, 0, 8'h00);
    push_slots(16,  8,  1, 8'h00);
    push_slots(32,  8,  2, 8'h00);
    push_slots(128, 8,  0, 8'h00);
    push_slots(144, 8,  7, 8'h00);
    push_slots(160, 16, 7, 8'h01);
    push_slots(192, 8,  0, 8'h00);
    push_slots(240, 8,  3, 8'h00);

    for (int i = 0; i < ND; i++) begin
      write = 1'b1;
      sel   = 4'(i);
      num   = 4'(i + 1);
      @(posedge clk);
      #1;
    end
    write = 1'b0;

    wait_until(20);
    scroll_en = 1'b1;
    direction = 1'b1;
    wait_until(540);
    direction = 1'b0;
    wait_until(600);
    scroll_en = 1'b0;

    wait_until(610);
    write = 1'b1;
    sel   = 4'hC;
    num   = 4'h5;
    @(posedge clk);
    #1;
    sel   = 4'h9;
    num   = 4'hF;
    @(posedge clk);
    #1;
    write      = 1'b0;
    blank_mask = 8'h01;
    wait_until(615);
    watch_fe = 1'b1;
    wait_until(710);
    watch_fe = 1'b0;

    wait_until(712);
    blank_mask = 8'h00;
    scroll_en  = 1'b1;
    direction  = 1'b1;
    wait_until(970);
    scroll_en = 1'b0;

    wait_until(1000);
    reset = 1'b1;
    @(posedge clk);
    #1;
    epoch = 1;
    for (int i = 0; i < ND; i++) regs_exp[i] = 4'h0;
    push_direct(100000, {8'hFF, 7'h7F, 1'b0, 1'b0});
    push_slots(0, 8, 0, 8'h00);
    reset = 1'b0;

    wait_until(40);
    done = 1'b1;
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
